// File: rtl/sevenseg_mux_driver.sv
// sevenseg_mux_driver
// Time-multiplexed driver for a DIGITS-wide seven-segment display. A shadow
// copy of the value and decimal points is captured on load, and one digit is
// driven at a time. Each digit stays on for REFRESH_DIV clock cycles.
// Digit 0 is the rightmost, least significant digit.
//
// Ports:
//   clk       system clock, everything on the rising edge
//   reset     synchronous, active-high reset
//   data      4*DIGITS bits, nibble i is digit i
//   dp_in     decimal point request per digit
//   load      capture data/dp_in into the shadow registers
//   hex_mode  1 = nibbles 10-15 shown as A..F, 0 = shown blank
//   blank_lz  1 = suppress leading zeros (digit 0 always shown)
//   an        digit enables, one-hot in the active level
//   y         segments {a,b,c,d,e,f,g}, y[6] = a
//   dp        decimal point for the current digit
module sevenseg_mux_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            y,
  output logic                  dp
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic INV = (ACTIVE_LOW != 0);

  logic [PW-1:0]       prescaler;
  logic [IW-1:0]       digitIdx;
  logic [4*DIGITS-1:0] shadowData;
  logic [DIGITS-1:0]   shadowDp;
  logic                tick;

  logic [3:0]          curNibble;
  logic                curDp;
  logic                lzBlank;
  logic                allZero;
  logic [DIGITS-1:0]   anHigh;
  logic [6:0]          segHigh;

  // Active-high abcdefg pattern for one hex nibble.
  function automatic logic [6:0] decodeHex(input logic [3:0] nib);
    case (nib)
      4'h0: decodeHex = 7'h7E;
      4'h1: decodeHex = 7'h30;
      4'h2: decodeHex = 7'h6D;
      4'h3: decodeHex = 7'h79;
      4'h4: decodeHex = 7'h33;
      4'h5: decodeHex = 7'h5B;
      4'h6: decodeHex = 7'h5F;
      4'h7: decodeHex = 7'h70;
      4'h8: decodeHex = 7'h7F;
      4'h9: decodeHex = 7'h7B;
      4'hA: decodeHex = 7'h77;
      4'hB: decodeHex = 7'h1F;
      4'hC: decodeHex = 7'h4E;
      4'hD: decodeHex = 7'h3D;
      4'hE: decodeHex = 7'h4F;
      default: decodeHex = 7'h47;
    endcase
  endfunction

  assign tick = (prescaler == PRE_LAST);

  // Prescaler and digit index advance together: the index only moves on
  // the last prescaler count, so every digit gets exactly REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      digitIdx  <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        digitIdx <= (digitIdx == IDX_LAST) ? '0 : digitIdx + 1'b1;
      end
    end
  end

  // Shadow registers decouple the display from the datapath; inputs only
  // matter on a load edge, and reset takes priority over a concurrent load.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadowData <= '0;
      shadowDp   <= '0;
    end else if (load) begin
      shadowData <= data;
      shadowDp   <= dp_in;
    end
  end

  // Select the current digit and work out leading-zero blanking. Scanning
  // from the top digit down, allZero tracks whether every nibble from the
  // top through digit j is zero; the current digit is blanked if that holds
  // at its own position (never for digit 0).
  always_comb begin
    curNibble = '0;
    curDp     = 1'b0;
    lzBlank   = 1'b0;
    allZero   = 1'b1;
    anHigh    = '0;
    for (int j = DIGITS - 1; j >= 0; j--) begin
      allZero = allZero & (shadowData[4*j +: 4] == 4'h0);
      if (j == int'(digitIdx)) begin
        curNibble = shadowData[4*j +: 4];
        curDp     = shadowDp[j];
        anHigh[j] = 1'b1;
        if (j != 0) begin
          lzBlank = allZero;
        end
      end
    end
  end

  // Segment pattern in active-high form; blanking removes segments only,
  // the anode and decimal point still follow the scan and shadow.
  always_comb begin
    segHigh = decodeHex(curNibble);
    if ((blank_lz && lzBlank) || (!hex_mode && curNibble > 4'd9)) begin
      segHigh = 7'h00;
    end
  end

  // Output register: one cycle behind the index, polarity applied here so
  // reset drives every output to its inactive level.
  always_ff @(posedge clk) begin
    if (reset) begin
      an <= {DIGITS{INV}};
      y  <= {7{INV}};
      dp <= INV;
    end else begin
      an <= anHigh ^ {DIGITS{INV}};
      y  <= segHigh ^ {7{INV}};
      dp <= curDp ^ INV;
    end
  end

endmodule

// File: doc/sevenseg_mux_driver.md
Name: sevenseg_mux_driver

Overview:
Time-multiplexed driver for a DIGITS-wide common-anode/cathode seven-segment display, the successor to the single-digit sevenseg decoder. It holds a loadable shadow copy of the BCD/hex value and scans one digit at a time at a divided refresh rate. It also provides a decimal point per digit, leading-zero blanking, a hex/decimal mode and selectable output polarity. It sits between the datapath's value registers and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned (>=2)
REFRESH_DIV, 50000, clk cycles per digit slot (>=2)
ACTIVE_LOW, 1, 1 = segment, dp and anode outputs active-low; 0 = active-high

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
data  input  4*DIGITS  nibble i = digit i (digit 0 = least significant, rightmost)
dp_in  input  DIGITS  decimal point request per digit
load  input  1  capture data/dp_in into shadow registers
hex_mode  input  1  1 = nibbles 10-15 shown as A,b,C,d,E,F; 0 = nibbles >9 shown blank
blank_lz  input  1  1 = suppress leading zeros
an  output  DIGITS  digit enables, one-hot in active level
y  output  7  segments {a,b,c,d,e,f,g}, y[6]=a
dp  output  1  decimal point for current digit

Behaviour:
- One clock (clk); reset is synchronous and active-high. All outputs registered.
- Reset: prescaler=0, digit index=0, shadow data=0, shadow dp=0; an all inactive, y all off, dp off (inactive = 1 when ACTIVE_LOW=1, else 0). First digit driven on the first edge after reset deasserts.
- Shadow load: load=1 at edge N -> shadow holds data/dp_in from edge N; display uses it from edge N+1. Without load, input changes have no effect. Load during reset is ignored (reset wins).
- Prescaler: counts 0..REFRESH_DIV-1, wraps to 0; tick = (count == REFRESH_DIV-1).
- Digit index: increments on tick, wraps DIGITS-1 -> 0. Each digit is active for exactly REFRESH_DIV cycles; full frame = DIGITS*REFRESH_DIV cycles.
- Output register: each edge loads an/y/dp from the current index and shadow. Output therefore lags the index by one cycle. Exactly one an bit is active at any time after reset.
- Decode (active-high abcdefg, hex): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47. hex_mode=0 with nibble>9 gives 00. ACTIVE_LOW=1 inverts y, dp and an.
- Leading-zero blanking (blank_lz=1): digit i is blanked (y off) if nibbles DIGITS-1 down to i are all zero, with i>0. Digit 0 is never blanked. A digit's dp still follows shadow dp when the digit is blanked. The digit's an remains active when blanked.
- Mode inputs hex_mode/blank_lz are not shadowed; they take effect on the next output register update.
- Reset mid-scan: returns to the reset state within one edge; the scan restarts at digit 0 with the prescaler at 0.

Test Plan:
- Reset, DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1 -> while reset=1, an=4'hF, y=7'h7F, dp=1. After release, an=4'b1110 for 4 cycles, then 1101, 1011, 0111, and back to 1110 (period 16).
- load data=16'h1234, dp_in=4'b0100 -> digit3 y=~30, digit2 y=~6D, dp=0 only in digit2 slot, digit1 y=~79, digit0 y=~33. Data changed without load -> no display change.
- hex_mode=1, data=16'hAbCF -> y=~77,~1F,~4E,~47. hex_mode=0 -> all four digits y=7'h7F; an still scans.
- blank_lz=1, data=16'h0050 -> digits 3,2 off, digit1 ~5B, digit0 ~7E. data=0 -> only digit0 shows ~7E.
- ACTIVE_LOW=0, data=16'h8888 -> y=7'h7F, active an bit=1, others 0.
- Assert reset for 1 cycle mid digit2 slot, with load=1 at the same edge -> outputs go to the reset state, shadow=0, and the scan resumes at digit0.
